// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score column generator and its
// comparator slices.
//   base_t : 2-bit nucleotide encoding (A=0, C=1, G=2, T=3)
//   code_t : 2-bit comparison code consumed by scoring_matrix
//   state_t: control state of score_column_gen
// ---------------------------------------------------------------------------
package score_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'd0,
    BASE_C = 2'd1,
    BASE_G = 2'd2,
    BASE_T = 2'd3
  } base_t;

  typedef logic [1:0] code_t;

  typedef enum logic {
    S_LOAD   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  localparam code_t CODE_MATCH      = 2'b11;
  localparam code_t CODE_TRANSITION = 2'b01;
  localparam code_t CODE_MISMATCH   = 2'b00;

  localparam int SCORE_N = 10;

endpackage

// File: rtl/score_column_gen_if.sv
// ---------------------------------------------------------------------------
// score_column_gen_if
// Handshake and column bus between a base source / scoring_matrix and
// score_column_gen.
//   ref_base/ref_valid/ref_ready : reference beat channel
//   qry_base/qry_valid/qry_ready : query beat channel
//   col_data[N-1:0][1:0]         : per-row comparison codes
//   col_valid[N-1:0]             : one-hot column strobe (or zero)
//   round_done                   : pulse with the last column of a round
// Modports: master = base source / column sink, slave = score_column_gen.
// ---------------------------------------------------------------------------
interface score_column_gen_if #(
  parameter int N = score_pkg::SCORE_N
);

  logic                ref_valid;
  logic [1:0]          ref_base;
  logic                ref_ready;
  logic                qry_valid;
  logic [1:0]          qry_base;
  logic                qry_ready;
  logic [N-1:0][1:0]   col_data;
  logic [N-1:0]        col_valid;
  logic                round_done;

  modport master (
    output ref_valid, ref_base, qry_valid, qry_base,
    input  ref_ready, qry_ready, col_data, col_valid, round_done
  );

  modport slave (
    input  ref_valid, ref_base, qry_valid, qry_base,
    output ref_ready, qry_ready, col_data, col_valid, round_done
  );

endinterface

// File: rtl/score_base_cmp.sv
// ---------------------------------------------------------------------------
// score_base_cmp
// Combinational comparison of one reference base against one query base.
//   ref_i  : reference base
//   qry_i  : query base
//   code_o : 11 = match, 01 = transition (A<->G, C<->T), 00 = other
// Optional feature macro: SCORE_COL_TRANSITION_EN. When undefined the
// transition code is never produced and only match/mismatch is decoded.
// ---------------------------------------------------------------------------
module score_base_cmp
  import score_pkg::*;
(
  input  base_t ref_i,
  input  base_t qry_i,
  output code_t code_o
);

  logic [1:0] x;

  // With this encoding, purine<->purine and pyrimidine<->pyrimidine
  // substitutions differ only in bit 1, so XOR == 2 marks a transition.
  assign x = ref_i ^ qry_i;

`ifdef SCORE_COL_TRANSITION_EN
  always_comb begin
    code_o = CODE_MISMATCH;
    if (x == 2'd0) begin
      code_o = CODE_MATCH;
    end else if (x == 2'd2) begin
      code_o = CODE_TRANSITION;
    end
  end
`else
  assign code_o = (x == 2'd0) ? CODE_MATCH : CODE_MISMATCH;
`endif

endmodule

// File: rtl/score_column_gen.sv
// ---------------------------------------------------------------------------
// score_column_gen
// Holds an N-base reference and streams query bases against it. Every
// accepted query base produces one registered column of N comparison codes
// with a one-hot column strobe; after N query bases the round ends and the
// block returns to reference loading.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (also zeroes reference and data)
//   clear : synchronous abort back to reference loading
//   bus   : score_column_gen_if.slave (ref/qry handshakes, column outputs)
// Optional feature macro: SCORE_COL_TRANSITION_EN (see score_base_cmp).
// ---------------------------------------------------------------------------
module score_column_gen
  import score_pkg::*;
#(
  parameter int N = SCORE_N
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  score_column_gen_if.slave bus
);

  localparam int               CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
  base_t              ref_q [N];
  base_t              ref_d [N];
  logic [N-1:0][1:0]  col_data_q, col_data_d;
  logic [N-1:0]       col_valid_q, col_valid_d;
  logic               round_done_q, round_done_d;

  code_t [N-1:0]      cmp_code;
  base_t              qry_b;
  logic               ref_acc;
  logic               qry_acc;

  assign qry_b = base_t'(bus.qry_base);

  // One comparator per reference row, all fed by the current query base.
  for (genvar r = 0; r < N; r++) begin : g_cmp
    score_base_cmp u_cmp (
      .ref_i  (ref_q[r]),
      .qry_i  (qry_b),
      .code_o (cmp_code[r])
    );
  end

  // Readies decode from state alone; clear vetoes any transfer that edge.
  assign bus.ref_ready = (state_q == S_LOAD);
  assign bus.qry_ready = (state_q == S_STREAM);
  assign ref_acc       = bus.ref_valid && bus.ref_ready && !clear;
  assign qry_acc       = bus.qry_valid && bus.qry_ready && !clear;

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    col_cnt_d    = col_cnt_q;
    ref_d        = ref_q;
    col_data_d   = col_data_q;
    col_valid_d  = '0;
    round_done_d = 1'b0;

    if (clear) begin
      state_d   = S_LOAD;
      row_cnt_d = '0;
      col_cnt_d = '0;
    end else if (ref_acc) begin
      ref_d[row_cnt_q] = base_t'(bus.ref_base);
      if (row_cnt_q == LAST) begin
        row_cnt_d = '0;
        state_d   = S_STREAM;
      end else begin
        row_cnt_d = row_cnt_q + CNT_W'(1);
      end
    end else if (qry_acc) begin
      col_data_d             = cmp_code;
      col_valid_d[col_cnt_q] = 1'b1;
      if (col_cnt_q == LAST) begin
        col_cnt_d    = '0;
        round_done_d = 1'b1;
        state_d      = S_LOAD;
      end else begin
        col_cnt_d = col_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      row_cnt_q    <= '0;
      col_cnt_q    <= '0;
      ref_q        <= '{default: BASE_A};
      col_data_q   <= '0;
      col_valid_q  <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      col_cnt_q    <= col_cnt_d;
      ref_q        <= ref_d;
      col_data_q   <= col_data_d;
      col_valid_q  <= col_valid_d;
      round_done_q <= round_done_d;
    end
  end

  assign bus.col_data   = col_data_q;
  assign bus.col_valid  = col_valid_q;
  assign bus.round_done = round_done_q;

endmodule
